jstack_pop_reader: RTL and testbench

//   Read-side engine for the JVM stack M9K RAM. Serves MCU pop requests (jsp-relative, consumes stack

---
 rtl/jstack_pop_reader.sv | 195 +++++++++++++++++++
 tb/tb_jstack_pop_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstack_pop_reader.sv
`default_nettype none
// ============================================================================
// Module      : jstack_pop_reader
// Description : Read-side engine for the JVM stack RAM.
//               - Pops (mode 0): read n words downward from jsp-1 and hand
//                 the decremented jsp back to the jsp register.
//               - Frame reads (mode 1): read n words upward from
//                 jframe+ofs. Addresses wrap modulo 2**ADDR_WIDTH.
//               Reads are issued back-to-back, one per cycle. Returned
//               words land in jop0..jop3. The MCU is stalled through
//               mcu_wait while a request is in flight.
// Ports       : sysclk/sysreset  - clock, asynchronous active-high reset
//               req, req_mode, req_cnt_m1, req_ofs - request interface
//               jsp_in, jframe_in                  - stack pointer inputs
//               ram_addr, ram_rden, ram_q          - RAM read port
//               jop_flat                           - {jop3,jop2,jop1,jop0}
//               jsp_out, jsp_load                  - jsp write-back
//               done, busy, mcu_wait               - status / stall
//               underflow, req_drop                - error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module jstack_pop_reader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  sysclk,
    input  logic                  sysreset,
    input  logic                  req,
    input  logic                  req_mode,
    input  logic [1:0]            req_cnt_m1,
    input  logic [ADDR_WIDTH-1:0] req_ofs,
    input  logic [ADDR_WIDTH-1:0] jsp_in,
    input  logic [ADDR_WIDTH-1:0] jframe_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rden,
    input  logic [15:0]           ram_q,
    output logic [63:0]           jop_flat,
    output logic [ADDR_WIDTH-1:0] jsp_out,
    output logic                  jsp_load,
    output logic                  done,
    output logic                  busy,
    output logic                  mcu_wait,
    output logic                  underflow,
    output logic                  req_drop
);

    localparam int AW = ADDR_WIDTH;
    localparam int L  = RAM_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_mode;
    logic [1:0]      r_cnt_m1;
    logic [AW-1:0]   r_addr;       // address of the next word to issue
    logic [AW-1:0]   r_jsp_new;
    logic [2:0]      r_iss;        // number of words issued so far
    logic            r_pv [L];     // read-return valid pipe
    logic [1:0]      r_pi [L];     // read-return jop index pipe
    logic [15:0]     r_jop [4];
    logic            r_underflow;
    logic            r_req_drop;

    logic [AW-1:0]   w_n;
    logic            w_uflow_hit;
    logic            w_accept;
    logic            w_issue;
    logic            w_cap;
    logic [1:0]      w_cap_idx;
    logic            w_last;
    logic            w_drop_hit;

    assign w_n         = AW'(req_cnt_m1) + AW'(1);
    assign w_uflow_hit = (r_state == S_IDLE) && req && !req_mode && (jsp_in < w_n);
    assign w_accept    = (r_state == S_IDLE) && req && !w_uflow_hit;
    assign w_issue     = (r_state == S_READ) && (r_iss <= {1'b0, r_cnt_m1});
    assign w_cap       = (r_state == S_READ) && r_pv[L-1];
    assign w_cap_idx   = r_pi[L-1];
    assign w_last      = w_cap && (w_cap_idx == r_cnt_m1);

    // A request seen in the last READ cycle would flag its drop in the DONE
    // cycle; that pulse is suppressed so req_drop never coincides with done.
    assign w_drop_hit  = (r_state != S_IDLE) && req && !((r_state == S_READ) && w_last);

    assign jop_flat  = {r_jop[3], r_jop[2], r_jop[1], r_jop[0]};
    assign underflow = r_underflow;
    assign req_drop  = r_req_drop;

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        ram_rden = 1'b0;
        ram_addr = '0;
        done     = 1'b0;
        jsp_load = 1'b0;
        jsp_out  = '0;
        busy     = (r_state != S_IDLE);
        mcu_wait = (r_state != S_IDLE) || req;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                if (w_issue) begin
                    ram_rden = 1'b1;
                    ram_addr = r_addr;
                end
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!r_mode) begin
                    jsp_load = 1'b1;
                    jsp_out  = r_jsp_new;
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, datapath and operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_cnt_m1    <= 2'd0;
            r_addr      <= '0;
            r_jsp_new   <= '0;
            r_iss       <= 3'd0;
            r_underflow <= 1'b0;
            r_req_drop  <= 1'b0;
            for (int k = 0; k < L; k++) begin
                r_pv[k] <= 1'b0;
                r_pi[k] <= 2'd0;
            end
            for (int j = 0; j < 4; j++) begin
                r_jop[j] <= 16'h0000;
            end
        end else begin
            r_state     <= w_next;
            r_underflow <= w_uflow_hit;
            r_req_drop  <= w_drop_hit;

            // Each issued read travels down the pipe and pops out exactly
            // when its data is valid on ram_q.
            r_pv[0] <= w_issue;
            r_pi[0] <= r_iss[1:0];
            for (int k = 1; k < L; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pi[k] <= r_pi[k-1];
            end

            if (w_accept) begin
                r_mode    <= req_mode;
                r_cnt_m1  <= req_cnt_m1;
                r_iss     <= 3'd0;
                r_jsp_new <= jsp_in - w_n;
                r_addr    <= req_mode ? (jframe_in + req_ofs) : (jsp_in - AW'(1));
                // Slots beyond this request's word count read back as zero.
                for (int j = 0; j < 4; j++) begin
                    if (2'(j) > req_cnt_m1) begin
                        r_jop[j] <= 16'h0000;
                    end
                end
            end else if (w_issue) begin
                r_iss  <= r_iss + 3'd1;
                r_addr <= r_mode ? (r_addr + AW'(1)) : (r_addr - AW'(1));
            end

            if (w_cap) begin
                r_jop[w_cap_idx] <= ram_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jstack_pop_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_jstack_pop_reader
// Description : Directed self-checking bench for jstack_pop_reader with a
//               two-cycle-latency stack RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jstack_pop_reader;

    logic        sysclk;
    logic        sysreset;
    logic        req;
    logic        req_mode;
    logic [1:0]  req_cnt_m1;
    logic [9:0]  req_ofs;
    logic [9:0]  jsp_in;
    logic [9:0]  jframe_in;
    logic [9:0]  ram_addr;
    logic        ram_rden;
    logic [15:0] ram_q;
    logic [63:0] jop_flat;
    logic [9:0]  jsp_out;
    logic        jsp_load;
    logic        done;
    logic        busy;
    logic        mcu_wait;
    logic        underflow;
    logic        req_drop;

    int total;
    int bad;

    logic [15:0] mem [1024];
    logic [15:0] r_d1;

    jstack_pop_reader #(
        .ADDR_WIDTH (10),
        .RAM_LATENCY(2)
    ) dut (
        .sysclk    (sysclk),
        .sysreset  (sysreset),
        .req       (req),
        .req_mode  (req_mode),
        .req_cnt_m1(req_cnt_m1),
        .req_ofs   (req_ofs),
        .jsp_in    (jsp_in),
        .jframe_in (jframe_in),
        .ram_addr  (ram_addr),
        .ram_rden  (ram_rden),
        .ram_q     (ram_q),
        .jop_flat  (jop_flat),
        .jsp_out   (jsp_out),
        .jsp_load  (jsp_load),
        .done      (done),
        .busy      (busy),
        .mcu_wait  (mcu_wait),
        .underflow (underflow),
        .req_drop  (req_drop)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Two-cycle read latency RAM model
    always @(posedge sysclk) begin
        r_d1  <= mem[ram_addr];
        ram_q <= r_d1;
    end

    task automatic test_reset();
        sysreset = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 sysreset = 1'b0;
        @(negedge sysclk);
        total++;
        if ({ram_addr, ram_rden, jsp_out, jsp_load, done, busy, mcu_wait, underflow, req_drop} !== '0) begin
            bad++;
            $display("FAIL reset_outputs addr=%h rden=%b jsp_out=%h load=%b done=%b busy=%b wait=%b uf=%b drop=%b",
                     ram_addr, ram_rden, jsp_out, jsp_load, done, busy, mcu_wait, underflow, req_drop);
        end
        total++;
        if (jop_flat !== 64'h0) begin
            bad++;
            $display("FAIL reset_jop got=%h exp=0", jop_flat);
        end
        @(posedge sysclk); #1;
    endtask

    task automatic test_pop();
        logic [9:0] ea;
        mem[4] = 16'h1111;
        mem[3] = 16'h2222;
        jsp_in = 10'd5; req_mode = 1'b0; req_cnt_m1 = 2'd1; req = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge sysclk);
            ea = (c == 1) ? 10'd4 : (c == 2) ? 10'd3 : 10'd0;
            total++;
            if (ram_rden !== (c == 1 || c == 2) || ram_addr !== ea) begin
                bad++;
                $display("FAIL pop_read c=%0d rden=%b addr=%h exp_addr=%h", c, ram_rden, ram_addr, ea);
            end
            total++;
            if (done !== (c == 5) || jsp_load !== (c == 5)) begin
                bad++;
                $display("FAIL pop_done c=%0d done=%b load=%b exp=%b", c, done, jsp_load, (c == 5));
            end
            total++;
            if (mcu_wait !== (c <= 5)) begin
                bad++;
                $display("FAIL pop_wait c=%0d got=%b exp=%b", c, mcu_wait, (c <= 5));
            end
            if (c == 5) begin
                total++;
                if (jsp_out !== 10'd3) begin
                    bad++;
                    $display("FAIL pop_jsp_out got=%h exp=3", jsp_out);
                end
            end
            @(posedge sysclk); #1;
            req = 1'b0;
        end
        total++;
        if (jop_flat !== 64'h0000_0000_2222_1111) begin
            bad++;
            $display("FAIL pop_jop got=%h exp=%h", jop_flat, 64'h0000_0000_2222_1111);
        end
    endtask

    task automatic test_underflow();
        jsp_in = 10'd1; req_mode = 1'b0; req_cnt_m1 = 2'd2; req = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge sysclk);
            total++;
            if (underflow !== (c == 1)) begin
                bad++;
                $display("FAIL uf_pulse c=%0d got=%b exp=%b", c, underflow, (c == 1));
            end
            total++;
            if (ram_rden !== 1'b0 || done !== 1'b0 || jsp_load !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL uf_quiet c=%0d rden=%b done=%b load=%b busy=%b exp=0", c, ram_rden, done, jsp_load, busy);
            end
            total++;
            if (mcu_wait !== (c == 0)) begin
                bad++;
                $display("FAIL uf_wait c=%0d got=%b exp=%b", c, mcu_wait, (c == 0));
            end
            @(posedge sysclk); #1;
            req = 1'b0;
        end
        total++;
        if (jop_flat !== 64'h0000_0000_2222_1111) begin
            bad++;
            $display("FAIL uf_jop got=%h exp=%h", jop_flat, 64'h0000_0000_2222_1111);
        end
    endtask

    task automatic test_busy_req();
        logic [9:0] ea;
        int ndone;
        ndone = 0;
        mem[9] = 16'h9009; mem[8] = 16'h8008; mem[7] = 16'h7007; mem[6] = 16'h6006;
        jsp_in = 10'd10; req_mode = 1'b0; req_cnt_m1 = 2'd3; req = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge sysclk);
            ea = (c >= 1 && c <= 4) ? 10'(10 - c) : 10'd0;
            total++;
            if (ram_rden !== (c >= 1 && c <= 4) || ram_addr !== ea) begin
                bad++;
                $display("FAIL busy_read c=%0d rden=%b addr=%h exp_addr=%h", c, ram_rden, ram_addr, ea);
            end
            total++;
            if (req_drop !== (c == 3)) begin
                bad++;
                $display("FAIL busy_drop c=%0d got=%b exp=%b", c, req_drop, (c == 3));
            end
            total++;
            if (done !== (c == 7)) begin
                bad++;
                $display("FAIL busy_done c=%0d got=%b exp=%b", c, done, (c == 7));
            end
            if (done === 1'b1) ndone++;
            if (c == 7) begin
                total++;
                if (jsp_load !== 1'b1 || jsp_out !== 10'd6) begin
                    bad++;
                    $display("FAIL busy_jsp load=%b jsp_out=%h exp=1/006", jsp_load, jsp_out);
                end
            end
            @(posedge sysclk); #1;
            // A second request and a jsp change mid-operation must not matter
            req    = (c == 1);
            jsp_in = (c == 1) ? 10'd3 : 10'd10;
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL busy_done_count got=%0d exp=1", ndone);
        end
        total++;
        if (jop_flat !== 64'h6006_7007_8008_9009) begin
            bad++;
            $display("FAIL busy_jop got=%h exp=%h", jop_flat, 64'h6006_7007_8008_9009);
        end
    endtask

    task automatic test_frame_wrap();
        logic [9:0] ea;
        mem[10'h3FF] = 16'hA001; mem[10'h000] = 16'hA002; mem[10'h001] = 16'hA003;
        jframe_in = 10'h3FE; req_ofs = 10'd1; req_mode = 1'b1; req_cnt_m1 = 2'd2; req = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            @(negedge sysclk);
            ea = (c == 1) ? 10'h3FF : (c == 3) ? 10'h001 : 10'h000;
            total++;
            if (ram_rden !== (c >= 1 && c <= 3) || ram_addr !== ea) begin
                bad++;
                $display("FAIL frame_read c=%0d rden=%b addr=%h exp_addr=%h", c, ram_rden, ram_addr, ea);
            end
            total++;
            if (done !== (c == 6) || jsp_load !== 1'b0) begin
                bad++;
                $display("FAIL frame_done c=%0d done=%b load=%b exp_done=%b", c, done, jsp_load, (c == 6));
            end
            @(posedge sysclk); #1;
            req = 1'b0;
            jframe_in = 10'h100;
            req_ofs   = 10'h020;
        end
        total++;
        if (jop_flat !== 64'h0000_A003_A002_A001) begin
            bad++;
            $display("FAIL frame_jop got=%h exp=%h", jop_flat, 64'h0000_A003_A002_A001);
        end
    endtask

    task automatic test_reset_mid();
        jsp_in = 10'd10; req_mode = 1'b0; req_cnt_m1 = 2'd3; req = 1'b1;
        @(posedge sysclk); #1;
        req = 1'b0;
        @(posedge sysclk); #1;
        sysreset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || jop_flat !== 64'h0 || ram_rden !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_clear busy=%b jop=%h rden=%b exp=0", busy, jop_flat, ram_rden);
        end
        @(posedge sysclk); #1;
        sysreset = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge sysclk);
            total++;
            if (done !== 1'b0 || jsp_load !== 1'b0 || jop_flat !== 64'h0) begin
                bad++;
                $display("FAIL rstmid_quiet c=%0d done=%b load=%b jop=%h exp=0", c, done, jsp_load, jop_flat);
            end
            @(posedge sysclk); #1;
        end
        mem[0] = 16'hBEEF;
        jsp_in = 10'd1; req_mode = 1'b0; req_cnt_m1 = 2'd0; req = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge sysclk);
            total++;
            if (done !== (c == 4) || jsp_load !== (c == 4)) begin
                bad++;
                $display("FAIL rstmid_pop_done c=%0d done=%b load=%b exp=%b", c, done, jsp_load, (c == 4));
            end
            if (c == 4) begin
                total++;
                if (jsp_out !== 10'd0) begin
                    bad++;
                    $display("FAIL rstmid_jsp got=%h exp=0", jsp_out);
                end
            end
            @(posedge sysclk); #1;
            req = 1'b0;
        end
        total++;
        if (jop_flat !== 64'h0000_0000_0000_BEEF) begin
            bad++;
            $display("FAIL rstmid_jop got=%h exp=%h", jop_flat, 64'h0000_0000_0000_BEEF);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 16'h0500);
        sysreset   = 1'b1;
        req        = 1'b0;
        req_mode   = 1'b0;
        req_cnt_m1 = 2'd0;
        req_ofs    = '0;
        jsp_in     = '0;
        jframe_in  = '0;

        test_reset();
        test_pop();
        test_underflow();
        test_busy_req();
        test_frame_wrap();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
